// File: rtl/default_slave_param.sv
// AHB default slave: answers transfers to unmapped address space.
// Configurable ERROR or OKAY response, with a small status block that records
// the most recent unmapped access and counts accepted ones (saturating).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no response pending; zero-wait OKAY
// ST_ERR1 | first ERROR cycle: wait state (HREADYOUT=0, HRESP=1)
// ST_ERR2 | second ERROR cycle: completes (HREADYOUT=1, HRESP=1)
module default_slave_param #(
  parameter int DATA_WIDTH = 64,
  parameter int ERR_MODE   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [31:0]           HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  clr_status,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_valid,
  output logic [31:0]           err_addr,
  output logic                  err_write,
  output logic [2:0]            err_size
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Write data, burst, protection and lock carry no meaning for this slave;
  // HTRANS[0] only distinguishes SEQ/NONSEQ and BUSY/IDLE, both irrelevant here.
  logic unused_inputs;
  assign unused_inputs = ^{HWDATA, HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // The wait state forces HREADY low on the bus, so nothing is taken in ST_ERR1.
  assign accept = HSEL && HREADY && HTRANS[1] && (state != ST_ERR1);

  assign HRDATA = '0;

  // State register; reset aborts any ERROR response in flight.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; in OKAY mode the FSM never leaves ST_IDLE.
  always_comb begin
    state_nxt = state;
    if (ERR_MODE == 0) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = accept ? ST_ERR1 : ST_IDLE;
        ST_ERR1: state_nxt = ST_ERR2;
        ST_ERR2: state_nxt = accept ? ST_ERR1 : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bus response decoded purely from the state register.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  // Status capture and saturating count; an accept takes priority over a clear.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      err_count <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
      err_size  <= '0;
    end else if (accept) begin
      err_valid <= 1'b1;
      err_addr  <= HADDR;
      err_write <= HWRITE;
      err_size  <= HSIZE;
      if (clr_status)               err_count <= CNT_ONE;
      else if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
    end else if (clr_status) begin
      err_count <= '0;
      err_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_default_slave_param.sv
// Bench for default_slave_param: instance A (ERR_MODE=1, CNT_WIDTH=2) and
// instance B (ERR_MODE=0, DATA_WIDTH=128). Expected responses are queued when
// a transfer is driven and popped as each response cycle completes.
module tb_default_slave_param;

  logic         HCLK = 1'b0;
  logic         hreset;
  logic         hsel_a, hsel_b, hready, hwrite, clr;
  logic [1:0]   htrans;
  logic [2:0]   hsize;
  logic [31:0]  haddr;
  logic [2:0]   hburst = 3'b011;
  logic [3:0]   hprot = 4'b0011;
  logic         hmastlock = 1'b0;
  logic [63:0]  hwdata_a = 64'hDEAD_BEEF_CAFE_F00D;
  logic [127:0] hwdata_b = {4{32'hA5A5_5A5A}};

  logic         rdyo_a, resp_a, valid_a, write_a;
  logic [63:0]  rdata_a;
  logic [1:0]   cnt_a;
  logic [31:0]  addr_a;
  logic [2:0]   size_a;

  logic         rdyo_b, resp_b, valid_b, write_b;
  logic [127:0] rdata_b;
  logic [7:0]   cnt_b;
  logic [31:0]  addr_b;
  logic [2:0]   size_b;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  int         m_cnt_a, m_cnt_b;
  logic       m_valid_a, m_valid_b, m_write_a;
  logic [31:0] m_addr_a, m_addr_b;
  logic [2:0]  m_size_a;

  always #5 HCLK = ~HCLK;

  default_slave_param #(.DATA_WIDTH(64), .ERR_MODE(1), .CNT_WIDTH(2)) dut_a (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel_a), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HADDR(haddr), .HWDATA(hwdata_a), .clr_status(clr),
    .HREADYOUT(rdyo_a), .HRESP(resp_a), .HRDATA(rdata_a), .err_count(cnt_a),
    .err_valid(valid_a), .err_addr(addr_a), .err_write(write_a), .err_size(size_a)
  );

  default_slave_param #(.DATA_WIDTH(128), .ERR_MODE(0), .CNT_WIDTH(8)) dut_b (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel_b), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HADDR(haddr), .HWDATA(hwdata_b), .clr_status(clr),
    .HREADYOUT(rdyo_b), .HRESP(resp_b), .HRDATA(rdata_b), .err_count(cnt_b),
    .err_valid(valid_b), .err_addr(addr_b), .err_write(write_b), .err_size(size_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("a_count", 128'(cnt_a), 128'(m_cnt_a));
    chk("a_valid", 128'(valid_a), 128'(m_valid_a));
    chk("a_addr", 128'(addr_a), 128'(m_addr_a));
    chk("a_write", 128'(write_a), 128'(m_write_a));
    chk("a_size", 128'(size_a), 128'(m_size_a));
    chk("a_rdata", 128'(rdata_a), 128'(0));
    chk("b_count", 128'(cnt_b), 128'(m_cnt_b));
    chk("b_valid", 128'(valid_b), 128'(m_valid_b));
    chk("b_addr", 128'(addr_b), 128'(m_addr_b));
    chk("b_rdata", rdata_b, 128'(0));
  endtask

  // Reset pulsed mid-cycle; outputs must clear before the next clock edge.
  task automatic reset_pulse();
    #1;
    hreset = 1'b0;
    hsel_a = 1'b0; hsel_b = 1'b0; hready = 1'b1; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b000; haddr = 32'h0; clr = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_valid_a = 1'b0; m_valid_b = 1'b0;
    m_addr_a = 32'h0; m_addr_b = 32'h0; m_write_a = 1'b0; m_size_a = 3'b000;
    exp_q.delete();
    #1;
    chk("rst_a_resp", 128'({rdyo_a, resp_a}), 128'(2'b10));
    chk("rst_b_resp", 128'({rdyo_b, resp_b}), 128'(2'b10));
    chk_status();
    #1;
    hreset = 1'b1;
  endtask

  // One bus cycle: drive, update the model, clock, then compare.
  task automatic cyc(input logic sel, input logic rdy, input logic wr,
                     input logic [1:0] tr, input logic [2:0] sz,
                     input logic [31:0] addr, input logic cl, input logic to_b);
    logic acc_a, acc_b;
    logic [1:0] exp;
    hsel_a = sel & ~to_b;
    hsel_b = sel & to_b;
    hready = rdy; hwrite = wr; htrans = tr; hsize = sz; haddr = addr; clr = cl;
    acc_a = hsel_a & rdy & tr[1];
    acc_b = hsel_b & rdy & tr[1];
    if (acc_a) begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b11);
      m_valid_a = 1'b1; m_addr_a = addr; m_write_a = wr; m_size_a = sz;
      m_cnt_a = cl ? 1 : ((m_cnt_a == 3) ? 3 : m_cnt_a + 1);
    end else if (cl) begin
      m_cnt_a = 0; m_valid_a = 1'b0;
    end
    if (acc_b) begin
      m_valid_b = 1'b1; m_addr_b = addr;
      m_cnt_b = cl ? 1 : ((m_cnt_b == 255) ? 255 : m_cnt_b + 1);
    end else if (cl) begin
      m_cnt_b = 0; m_valid_b = 1'b0;
    end
    @(posedge HCLK);
    #1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
    chk("a_resp", 128'({rdyo_a, resp_a}), 128'(exp));
    chk("b_resp", 128'({rdyo_b, resp_b}), 128'(2'b10));
    chk_status();
  endtask

  initial begin
    hreset = 1'b0;
    hsel_a = 1'b0; hsel_b = 1'b0; hready = 1'b1; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b000; haddr = 32'h0; clr = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_valid_a = 1'b0; m_valid_b = 1'b0;
    m_addr_a = 32'h0; m_addr_b = 32'h0; m_write_a = 1'b0; m_size_a = 3'b000;

    reset_pulse();

    // IDLE/BUSY with HSEL high: never accepted, always OKAY.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b1, (i % 2 == 1) ? 2'b01 : 2'b00, 3'b010,
          32'h1000_0000 + 32'(i), 1'b0, 1'b0);
    end

    // First edge after reset release accepts a NONSEQ write.
    reset_pulse();
    cyc(1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h4000_0010, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);

    // Clear alone: count and valid drop, capture registers hold.
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 1'b0);

    // Back-to-back NONSEQ then SEQ accepted in ST_ERR2.
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 3'b011, 32'h2000_0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 3'b011, 32'h2000_0008, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 3'b011, 32'h2000_0008, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);

    // Three more accepts: count saturates at 3 with CNT_WIDTH=2.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'(i % 2), 2'b10, 3'(i), 32'h2100_0000 + 32'(i * 4), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    end

    // Clear together with accept: accept wins, count restarts at 1.
    cyc(1'b1, 1'b1, 1'b1, 2'b10, 3'b000, 32'h3000_0004, 1'b1, 1'b0);
    // Clear during ST_ERR1 leaves the ERROR response untouched.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);

    // Reset while in ST_ERR1 aborts the response asynchronously.
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 32'h5000_0000, 1'b0, 1'b0);
    reset_pulse();
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b0);

    // OKAY-mode instance: zero-wait reads, still counted.
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 3'b100, 32'h6000_0000, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 3'b100, 32'h6000_0010, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/default_slave_param.md
DEFAULT_SLAVE_PARAM -- requirements
Module: default_slave_param

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 64: width of HWDATA/HRDATA; legal values 32, 64, 128.
REQ-002 The block SHALL take parameter ERR_MODE, default 1: 1 = two-cycle AHB ERROR response; 0 = zero-wait OKAY with HRDATA = 0.
REQ-003 The block SHALL take parameter CNT_WIDTH, default 8: width of the unmapped-access counter.
REQ-004 Port list (name, direction, width, meaning), with clock and reset first; unused inputs SHALL be accepted and ignored:
- HCLK  in  1  single clock; all state changes on its rising edge.
- HRESET  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready.
- HWRITE  in  1  transfer direction.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HBURST  in  3  ignored.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HADDR  in  32  address.
- HWDATA  in  DATA_WIDTH  write data, ignored.
- clr_status  in  1  synchronous clear of the status outputs.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  constant 0.
- err_count  out  CNT_WIDTH  count of accepted unmapped transfers.
- err_valid  out  1  at least one access captured since reset or clear.
- err_addr  out  32  HADDR of the most recent accepted transfer.
- err_write  out  1  HWRITE of the most recent accepted transfer.
- err_size  out  3  HSIZE of the most recent accepted transfer.

Function
REQ-005 A transfer SHALL be accepted in a cycle when HSEL=1, HREADY=1 and HTRANS is NONSEQ (2'b10) or SEQ (2'b11).
REQ-006 IDLE (2'b00) and BUSY (2'b01) transfers SHALL never be accepted and SHALL always receive a zero-wait OKAY response.
REQ-007 The FSM SHALL have three states, ST_IDLE, ST_ERR1 and ST_ERR2, with outputs registered from state:
- ST_IDLE: HREADYOUT=1, HRESP=0.
- ST_ERR1: HREADYOUT=0, HRESP=1.
- ST_ERR2: HREADYOUT=1, HRESP=1.
REQ-008 With ERR_MODE=1, the FSM SHALL make these transitions:
- ST_IDLE -> ST_ERR1 on accept; otherwise stay in ST_IDLE.
- ST_ERR1 -> ST_ERR2 unconditionally.
- ST_ERR2 -> ST_ERR1 on accept; otherwise -> ST_IDLE.
REQ-009 As a result, each accepted transfer SHALL see exactly one wait cycle (ERROR, HREADYOUT=0) followed by one ERROR cycle with HREADYOUT=1.
REQ-010 In ST_ERR1, HREADY is low, so no transfer can be accepted; the block SHALL NOT queue one.
REQ-011 A master cancelling the next transfer (HTRANS=IDLE) during ST_ERR2 SHALL return the FSM to ST_IDLE with no count and no capture.
REQ-012 With ERR_MODE=0, the FSM SHALL remain in ST_IDLE permanently: every transfer gets a zero-wait OKAY.
REQ-013 Status capture and counting SHALL still operate in both ERR_MODE settings.
REQ-014 HRDATA SHALL be all-zero at all times, for any DATA_WIDTH.
REQ-015 On every accept, err_addr, err_write and err_size SHALL load HADDR, HWRITE and HSIZE at the next HCLK edge, and err_valid SHALL be set to 1.
REQ-016 On every accept, err_count SHALL increment by 1 and saturate at 2^CNT_WIDTH-1 with no wrap.
REQ-017 When clr_status=1 and there is no accept in the same cycle, err_count SHALL go to 0, err_valid to 0, and err_addr/err_write/err_size SHALL keep their values.
REQ-018 When clr_status=1 and an accept occur in the same cycle, err_count SHALL become 1, err_valid 1, and the capture registers SHALL load the new transfer (the accept wins).
REQ-019 clr_status SHALL NOT affect the FSM or the HREADYOUT/HRESP response in progress.

Reset
REQ-020 While HRESET=0, asynchronously and independent of HCLK: state=ST_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, err_count=0, err_valid=0, err_addr=0, err_write=0, err_size=0.
REQ-021 Reset asserted in ST_ERR1 or ST_ERR2 SHALL abort the response immediately, forcing HREADYOUT=1 and HRESP=0.
REQ-022 After reset release, the first rising HCLK edge SHALL be able to accept a transfer.

Verification
REQ-023 Reset, then NONSEQ write to 0x4000_0010 with HSIZE=3'b010 (ERR_MODE=1) -> cycle+1: HREADYOUT=0, HRESP=1; cycle+2: HREADYOUT=1, HRESP=1; cycle+3: OKAY; err_count=1, err_addr=0x4000_0010, err_write=1, err_size=3'b010, err_valid=1.
REQ-024 Back-to-back NONSEQ then SEQ, with the SEQ accepted in ST_ERR2 -> response pattern ERR1, ERR2, ERR1, ERR2, IDLE; err_count=2; err_addr = second HADDR.
REQ-025 HTRANS=IDLE or BUSY with HSEL=1 for 10 cycles -> HREADYOUT=1, HRESP=0 throughout; err_count=0, err_valid=0.
REQ-026 CNT_WIDTH=2, with 5 accepted transfers -> err_count holds 3; then clr_status together with an accept -> err_count=1; clr_status alone -> err_count=0, err_valid=0, err_addr unchanged.
REQ-027 ERR_MODE=0, DATA_WIDTH=128, read NONSEQ -> zero-wait OKAY, HRDATA=128'h0, err_count=1.
REQ-028 HRESET pulsed low while in ST_ERR1 -> HREADYOUT=1 and HRESP=0 before the next HCLK edge, and all status outputs return to 0.
